// File: rtl/peak_search_ctrl_if.sv
// Result bus of the I/Q peak-search sequencer.
// One combined per-frame peak result with valid/ready handshake.
interface peak_search_ctrl_if #(
    parameter int DATA_LEN  = 64,
    parameter int INDEX_LEN = 32
);
    logic                 res_tvalid;
    logic                 res_tready;
    logic [INDEX_LEN-1:0] res_index_i;
    logic [INDEX_LEN-1:0] res_index_q;
    logic [DATA_LEN-1:0]  res_mag_i;
    logic [DATA_LEN-1:0]  res_mag_q;
    logic [15:0]          res_frame;
    logic [1:0]           res_flags;

    modport master (
        output res_tvalid,
        output res_index_i,
        output res_index_q,
        output res_mag_i,
        output res_mag_q,
        output res_frame,
        output res_flags,
        input  res_tready
    );

    modport slave (
        input  res_tvalid,
        input  res_index_i,
        input  res_index_q,
        input  res_mag_i,
        input  res_mag_q,
        input  res_frame,
        input  res_flags,
        output res_tready
    );
endinterface

// File: rtl/peak_search_ctrl.sv
// Frame sequencer for the dual-channel magnitude + peak-finder chain.
// Gates whole frames, collects both peaks, presents one result per frame.
module peak_search_ctrl #(
    parameter int DATA_LEN       = 64,
    parameter int INDEX_LEN      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [15:0]          cfg_num_frames,
    input  logic [DATA_LEN-1:0]  cfg_threshold,
    input  logic                 in_tvalid,
    input  logic                 in_tlast,
    output logic                 frame_enable,
    output logic [DATA_LEN-1:0]  threshold_out,
    input  logic                 pk_i_tvalid,
    input  logic                 pk_i_tlast,
    input  logic [INDEX_LEN-1:0] pk_i_index,
    input  logic [DATA_LEN-1:0]  pk_i_tdata,
    input  logic                 pk_q_tvalid,
    input  logic                 pk_q_tlast,
    input  logic [INDEX_LEN-1:0] pk_q_index,
    input  logic [DATA_LEN-1:0]  pk_q_tdata,
    peak_search_ctrl_if.master   res_if,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        WAIT_PEAK,
        PRESENT
    } state_t;

    state_t        state;
    logic [CW-1:0] to_cnt;
    logic          got_i;
    logic          got_q;
    logic          boundary;
    logic          hit_i;
    logic          hit_q;
    logic          capturing;
    logic          last_frame;

    // Frame boundary and first-tlast-wins capture qualifiers.
    always_comb begin
        boundary   = ~in_tvalid | in_tlast;
        capturing  = (state == RUN) || (state == WAIT_PEAK);
        hit_i      = capturing & pk_i_tvalid & pk_i_tlast & ~got_i;
        hit_q      = capturing & pk_q_tvalid & pk_q_tlast & ~got_q;
        last_frame = (cfg_num_frames != 16'd0) &&
                     (res_if.res_frame == cfg_num_frames - 16'd1);
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= IDLE;
            to_cnt             <= '0;
            got_i              <= 1'b0;
            got_q              <= 1'b0;
            frame_enable       <= 1'b0;
            threshold_out      <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            res_if.res_tvalid  <= 1'b0;
            res_if.res_index_i <= '0;
            res_if.res_index_q <= '0;
            res_if.res_mag_i   <= '0;
            res_if.res_mag_q   <= '0;
            res_if.res_frame   <= '0;
            res_if.res_flags   <= '0;
        end else begin
            done <= 1'b0;
            if (cfg_abort) begin
                state             <= IDLE;
                frame_enable      <= 1'b0;
                res_if.res_tvalid <= 1'b0;
                busy              <= 1'b0;
                got_i             <= 1'b0;
                got_q             <= 1'b0;
            end else begin
                if (hit_i) begin
                    res_if.res_index_i <= pk_i_index;
                    res_if.res_mag_i   <= pk_i_tdata;
                    got_i              <= 1'b1;
                end
                if (hit_q) begin
                    res_if.res_index_q <= pk_q_index;
                    res_if.res_mag_q   <= pk_q_tdata;
                    got_q              <= 1'b1;
                end
                unique case (state)
                    IDLE: begin
                        if (cfg_start) begin
                            state            <= ARM;
                            busy             <= 1'b1;
                            res_if.res_frame <= '0;
                        end
                    end
                    ARM: begin
                        if (boundary) begin
                            state            <= RUN;
                            frame_enable     <= 1'b1;
                            threshold_out    <= cfg_threshold;
                            res_if.res_flags <= '0;
                            got_i            <= 1'b0;
                            got_q            <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (in_tvalid && in_tlast) begin
                            state        <= WAIT_PEAK;
                            frame_enable <= 1'b0;
                            to_cnt       <= '0;
                        end
                    end
                    WAIT_PEAK: begin
                        to_cnt <= to_cnt + CW'(1);
                        if (got_i && got_q) begin
                            state             <= PRESENT;
                            res_if.res_tvalid <= 1'b1;
                        end else if (to_cnt == TO_LAST) begin
                            state             <= PRESENT;
                            res_if.res_tvalid <= 1'b1;
                            if (!got_i && !hit_i) begin
                                res_if.res_index_i  <= '1;
                                res_if.res_mag_i    <= '0;
                                res_if.res_flags[0] <= 1'b1;
                            end
                            if (!got_q && !hit_q) begin
                                res_if.res_index_q  <= '1;
                                res_if.res_mag_q    <= '0;
                                res_if.res_flags[1] <= 1'b1;
                            end
                        end
                    end
                    PRESENT: begin
                        if (res_if.res_tready) begin
                            res_if.res_tvalid <= 1'b0;
                            if (last_frame) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state            <= ARM;
                                res_if.res_frame <= res_if.res_frame + 16'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
